// File: rtl/lcd_time_writer_if.sv
// Signal bundle between the time writer and its surroundings: update request,
// BCD time inputs, LCD ready handshake in, and the LCD byte/status outputs.
interface lcd_time_writer_if;
  logic       update_i;
  logic [7:0] hh_bcd_i;
  logic [7:0] mm_bcd_i;
  logic [7:0] ss_bcd_i;
  logic       lcd_ready_i;
  logic [7:0] lcd_data_o;
  logic       lcd_send_o;
  logic       lcd_ins_data_o;
  logic       busy_o;
  logic       frame_done_o;
  logic       err_o;

  // Seen from the time writer itself
  modport slave (
    input  update_i, hh_bcd_i, mm_bcd_i, ss_bcd_i, lcd_ready_i,
    output lcd_data_o, lcd_send_o, lcd_ins_data_o, busy_o, frame_done_o, err_o
  );

  // Seen from whoever drives the requests and the LCD interface side
  modport master (
    output update_i, hh_bcd_i, mm_bcd_i, ss_bcd_i, lcd_ready_i,
    input  lcd_data_o, lcd_send_o, lcd_ins_data_o, busy_o, frame_done_o, err_o
  );
endinterface

// File: rtl/lcd_time_writer.sv
// Prints HH:MM:SS on LCD line 1: one set-DDRAM-address instruction followed by
// eight characters, each byte handed over with a send pulse and a ready
// low-then-high acknowledge, with a per-byte timeout that abandons the frame.
module lcd_time_writer #(
  parameter logic [7:0]  LINE_ADDR = 8'h80,
  parameter logic [7:0]  SEP_CHAR  = 8'h3A,
  parameter int unsigned PULSE_LEN = 3,
  parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
  input logic              clk,
  input logic              rst,
  lcd_time_writer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND,
    S_WAIT,
    S_NEXT
  } state_t;

  localparam logic [7:0]  PULSE_LAST = 8'(PULSE_LEN - 1);
  localparam logic [15:0] TMO_LAST   = TIMEOUT - 16'd1;

  state_t     state_q;
  logic       pending_q;
  logic       seen_low_q;
  logic [3:0] idx_q;
  logic [7:0] pcnt_q;
  logic [15:0] tmo_q;
  logic [7:0] hh_q;
  logic [7:0] mm_q;
  logic [7:0] ss_q;
  logic [7:0] data_q;
  logic       send_q;
  logic       ins_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;

  logic [3:0] idx_d;
  logic [7:0] byte_d;
  logic       ins_d;
  logic       wait_exit;
  logic       tmo_hit;

  // Digits 0-9 become ASCII '0'-'9'; anything else shows as '?'
  function automatic logic [7:0] digit_char(input logic [3:0] n);
    if (n > 4'd9) return 8'h3F;
    return 8'h30 + {4'd0, n};
  endfunction

  // Index of the byte about to be loaded: 0 when starting, +1 when advancing
  assign idx_d = (state_q == S_NEXT) ? idx_q + 4'd1 : 4'd0;

  // Byte table lookup from the snapshot registers
  always_comb begin
    byte_d = 8'h00;
    ins_d  = 1'b1;
    case (idx_d)
      4'd0: begin byte_d = LINE_ADDR; ins_d = 1'b0; end
      4'd1: byte_d = digit_char(hh_q[7:4]);
      4'd2: byte_d = digit_char(hh_q[3:0]);
      4'd3: byte_d = SEP_CHAR;
      4'd4: byte_d = digit_char(mm_q[7:4]);
      4'd5: byte_d = digit_char(mm_q[3:0]);
      4'd6: byte_d = SEP_CHAR;
      4'd7: byte_d = digit_char(ss_q[7:4]);
      4'd8: byte_d = digit_char(ss_q[3:0]);
      default: byte_d = 8'h00;
    endcase
  end

  // A byte is acknowledged once ready has been seen low and is now high again;
  // an acknowledge in the same cycle as the timeout still counts.
  assign wait_exit = (state_q == S_WAIT) && seen_low_q && bus.lcd_ready_i;
  assign tmo_hit   = (tmo_q == TMO_LAST) && !wait_exit;

  // Frame sequencer with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pending_q  <= 1'b0;
      seen_low_q <= 1'b0;
      idx_q      <= 4'd0;
      pcnt_q     <= 8'd0;
      tmo_q      <= 16'd0;
      hh_q       <= 8'd0;
      mm_q       <= 8'd0;
      ss_q       <= 8'd0;
      data_q     <= 8'd0;
      send_q     <= 1'b0;
      ins_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      // Requests accumulate into a single pending refresh from any state
      pending_q <= pending_q | bus.update_i;
      case (state_q)
        S_IDLE: begin
          if (pending_q && bus.lcd_ready_i) state_q <= S_START;
        end
        S_START: begin
          hh_q       <= bus.hh_bcd_i;
          mm_q       <= bus.mm_bcd_i;
          ss_q       <= bus.ss_bcd_i;
          // A request landing on the snapshot cycle still earns its own frame
          pending_q  <= bus.update_i;
          err_q      <= 1'b0;
          busy_q     <= 1'b1;
          idx_q      <= idx_d;
          data_q     <= byte_d;
          ins_q      <= ins_d;
          send_q     <= 1'b1;
          pcnt_q     <= 8'd0;
          tmo_q      <= 16'd0;
          seen_low_q <= 1'b0;
          state_q    <= S_SEND;
        end
        S_SEND, S_WAIT: begin
          if (!bus.lcd_ready_i) seen_low_q <= 1'b1;
          tmo_q <= tmo_q + 16'd1;
          if (state_q == S_SEND) begin
            pcnt_q <= pcnt_q + 8'd1;
            if (pcnt_q == PULSE_LAST) begin
              send_q  <= 1'b0;
              state_q <= S_WAIT;
            end
          end else if (wait_exit) begin
            state_q <= S_NEXT;
            if (idx_q == 4'd8) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
          end
          if (tmo_hit) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            send_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_NEXT: begin
          if (idx_q == 4'd8) begin
            state_q <= S_IDLE;
          end else begin
            idx_q      <= idx_d;
            data_q     <= byte_d;
            ins_q      <= ins_d;
            send_q     <= 1'b1;
            pcnt_q     <= 8'd0;
            tmo_q      <= 16'd0;
            seen_low_q <= 1'b0;
            state_q    <= S_SEND;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.lcd_data_o     = data_q;
  assign bus.lcd_send_o     = send_q;
  assign bus.lcd_ins_data_o = ins_q;
  assign bus.busy_o         = busy_q;
  assign bus.frame_done_o   = done_q;
  assign bus.err_o          = err_q;

endmodule
